video_pattern_gen: RTL and testbench
====================================

// Module: video_pattern_gen
// PURPOSE
// - Video source for the 2D FIR filter's input stream: drives y/dv/hs/vs for a 1600x900 luma frame.
// - Contains H/V timing counters, registered sync generation and a selectable 8-bit luma test pattern.
// - Sits ahead of fir_filter, bench-side or in place of the camera/decoder path on the board.
// - Its frame geometry must match the filter's line buffer depth (1600) and row limit (900).
// PARAMETERS
// H_ACTIVE 1600  active pixels per line
// H_FP     24    front porch after active, in clocks
// H_SYNC   80    hs_o pulse width, in clocks
// H_BP     96    back porch, in clocks (H_TOTAL = 1800)
// V_ACTIVE 900   active lines per frame
// V_FP     1     front porch, in lines
// V_SYNC   3     vs_o pulse width, in lines
// V_BP     96    back porch, in lines (V_TOTAL = 1000)
// CHK_LOG2 3     checkerboard square size = 2**CHK_LOG2 pixels
// PORTS
// clk       in   1   pixel clock
// rst       in   1   synchronous, active-high reset
// en_i      in   1   1 = run; 0 = freeze counters, force outputs low
// mode_i    in   2   pattern select: 0 solid, 1 H-ramp, 2 V-ramp, 3 checker
// solid_i   in   8   luma value for mode 0
// y_o       out  8   pixel luma, valid when dv_o=1, else 0
// dv_o      out  1   active-pixel strobe
// hs_o      out  1   horizontal sync, active-high pulse
// vs_o      out  1   vertical sync, active-high pulse
// frame_o   out  16  completed-frame counter, wraps at 65535
// BEHAVIOUR
// - Counters: h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1. h wraps to 0 and v increments at h=H_TOTAL-1.
//   v wraps to 0 at (H_TOTAL-1, V_TOTAL-1); frame_o increments on that same edge.
// - rst (priority over en_i): h=v=0, frame_o=0, mode latched to 0, y_o=0, dv_o=hs_o=vs_o=0.
// - en_i=0: counters hold, all outputs 0 except frame_o (holds). en_i=1 resumes from held position.
// - Outputs are registered from the current counter state: 1 clk latency.
//   The first edge after rst release with en_i=1 presents pixel (0,0) on the outputs.
// - dv_o = (h<H_ACTIVE) & (v<V_ACTIVE).
// - hs_o = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, on every line including vertical blanking.
// - vs_o = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, whole lines; hs_o keeps toggling during vs_o.
// - hs_o/vs_o are never asserted while dv_o=1, because the filter resets its write column and row bookkeeping on them.
// - mode_i and solid_i are sampled only at h=0,v=0 with en_i=1; mid-frame changes take effect next frame.
// - Pattern, with x=h, y=v during active:
//   - mode 0: solid
//   - mode 1: x[7:0] (wraps every 256)
//   - mode 2: y[7:0]
//   - mode 3: 8'hFF if x[CHK_LOG2]^y[CHK_LOG2], else 8'h00
// - Reset mid-frame: the next enabled edge restarts at pixel (0,0). There is no partial-line completion.
// - Parameters must satisfy: every field >= 1, H_TOTAL <= 2048, V_TOTAL <= 1024. Counters are 11 and 10 bits.
// TESTING
// T1 Defaults, rst then en_i=1, 2 frames:
//    - 1600 dv_o per line, 1,440,000 per frame
//    - hs_o period 1800 clks, width 80; hs_o rises 1624 clks after the first dv_o of a line
//    - vs_o width 5400 clks
//    - frame_o=2 after 3,600,000 clks
// T2 mode 1, line 0: y_o = 0,1,..,255,0,.. at pixels 0..257; y_o=0 in blanking; pixel 1599 = 8'h3F.
// T3 mode 3, CHK_LOG2=3:
//    - (x,y) = (0,0)->00, (8,0)->FF, (8,8)->00, (0,8)->FF
// T4 Switch mode 0->2 at mid-frame (v=450): the current frame stays solid; the next frame's line 5 reads 8'h05.
// T5 Small params (H 8/1/2/1, V 4/1/1/1):
//    - en_i low for 5 clks mid-line: outputs 0, position held, resumes the exact sequence
//    - rst mid-line: outputs 0 and restart at (0,0)
// T6 Drive fir_filter with defaults: its dv/hs/vs outputs equal this block's delayed 1 clk; no X on r_o after row 2.

Source files
------------

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// video_pattern_gen
//   H/V timing counters, registered sync and selectable 8-bit luma test pattern.
//   Revision: 1.0
// ============================================================================
module video_pattern_gen #(
  parameter int H_ACTIVE = 1600,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 80,
  parameter int H_BP     = 96,
  parameter int V_ACTIVE = 900,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 96,
  parameter int CHK_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [1:0]  mode_i,
  input  logic [7:0]  solid_i,
  output logic [7:0]  y_o,
  output logic        dv_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic [15:0] frame_o
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] c_H_LAST   = 11'(c_H_TOTAL - 1);
  localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] c_HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  c_V_LAST   = 10'(c_V_TOTAL - 1);
  localparam logic [9:0]  c_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  c_VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] r_h;
  logic [9:0]  r_v;
  logic [15:0] r_frame;
  logic [1:0]  r_mode;
  logic [7:0]  r_solid;
  logic [7:0]  r_y;
  logic        r_dv;
  logic        r_hs;
  logic        r_vs;

  logic        w_h_last;
  logic        w_v_last;
  logic        w_sof;
  logic        w_dv;
  logic        w_hs;
  logic        w_vs;
  logic [1:0]  w_mode;
  logic [7:0]  w_solid;
  logic [7:0]  w_pix;

  assign w_h_last = (r_h == c_H_LAST);
  assign w_v_last = (r_v == c_V_LAST);
  assign w_sof    = (r_h == '0) && (r_v == '0);
  assign w_dv     = (r_h < c_H_ACT) && (r_v < c_V_ACT);
  assign w_hs     = (r_h >= c_HS_BEG) && (r_h < c_HS_END);
  assign w_vs     = (r_v >= c_VS_BEG) && (r_v < c_VS_END);

  // Pixel (0,0) already uses the settings captured on its own edge.
  assign w_mode   = w_sof ? mode_i  : r_mode;
  assign w_solid  = w_sof ? solid_i : r_solid;

  always_comb begin
    w_pix = 8'h00;
    case (w_mode)
      2'd0:    w_pix = w_solid;
      2'd1:    w_pix = r_h[7:0];
      2'd2:    w_pix = r_v[7:0];
      default: w_pix = (r_h[CHK_LOG2] ^ r_v[CHK_LOG2]) ? 8'hFF : 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h     <= '0;
      r_v     <= '0;
      r_frame <= '0;
      r_mode  <= '0;
      r_solid <= '0;
      r_y     <= '0;
      r_dv    <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
    end else if (!en_i) begin
      r_y  <= '0;
      r_dv <= 1'b0;
      r_hs <= 1'b0;
      r_vs <= 1'b0;
    end else begin
      r_dv <= w_dv;
      r_hs <= w_hs;
      r_vs <= w_vs;
      r_y  <= w_dv ? w_pix : 8'h00;
      if (w_sof) begin
        r_mode  <= mode_i;
        r_solid <= solid_i;
      end
      if (w_h_last) begin
        r_h <= '0;
        if (w_v_last) begin
          r_v     <= '0;
          r_frame <= r_frame + 16'd1;
        end else begin
          r_v <= r_v + 10'd1;
        end
      end else begin
        r_h <= r_h + 11'd1;
      end
    end
  end

  assign y_o     = r_y;
  assign dv_o    = r_dv;
  assign hs_o    = r_hs;
  assign vs_o    = r_vs;
  assign frame_o = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_video_pattern_gen.sv
`default_nettype none
// ============================================================================
// tb_video_pattern_gen
//   Scoreboard bench: small-geometry instance plus a default-geometry instance.
//   Revision: 1.0
// ============================================================================
module tb_video_pattern_gen;

  typedef struct packed {
    logic [7:0]  y;
    logic        dv;
    logic        hs;
    logic        vs;
    logic [15:0] fr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small geometry: H 16/2/3/2 (23), V 10/1/2/1 (14), 4-pixel checker squares
  logic        s_rst = 1'b1, s_en = 1'b0;
  logic [1:0]  s_mode = 2'd0;
  logic [7:0]  s_solid = 8'h00;
  logic [7:0]  s_y;
  logic        s_dv, s_hs, s_vs;
  logic [15:0] s_fr;

  logic        d_rst = 1'b1, d_en = 1'b0;
  logic [1:0]  d_mode = 2'd0;
  logic [7:0]  d_solid = 8'h00;
  logic [7:0]  d_y;
  logic        d_dv, d_hs, d_vs;
  logic [15:0] d_fr;

  video_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .CHK_LOG2(2)
  ) dut_s (
    .clk(clk), .rst(s_rst), .en_i(s_en), .mode_i(s_mode), .solid_i(s_solid),
    .y_o(s_y), .dv_o(s_dv), .hs_o(s_hs), .vs_o(s_vs), .frame_o(s_fr)
  );

  video_pattern_gen dut_d (
    .clk(clk), .rst(d_rst), .en_i(d_en), .mode_i(d_mode), .solid_i(d_solid),
    .y_o(d_y), .dv_o(d_dv), .hs_o(d_hs), .vs_o(d_vs), .frame_o(d_fr)
  );

  int n_checks = 0;
  int n_errors = 0;

  exp_t q_s[$];
  exp_t q_d[$];

  int          ms_h = 0, ms_v = 0, md_h = 0, md_v = 0;
  logic [15:0] ms_fr = '0, md_fr = '0;
  logic [1:0]  ms_mode = '0, md_mode = '0;
  logic [7:0]  ms_solid = '0, md_solid = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge: returns the outputs after the edge.
  task automatic model_step(
    input int ha, input int hf, input int hsy, input int hb,
    input int va, input int vf, input int vsy, input int vb, input int chk,
    input logic rst, input logic en, input logic [1:0] mode, input logic [7:0] solid,
    inout int h, inout int v, inout logic [15:0] fr,
    inout logic [1:0] lm, inout logic [7:0] ls, output exp_t e);
    logic [1:0] em;
    logic [7:0] es;
    int ht, vt;
    ht = ha + hf + hsy + hb;
    vt = va + vf + vsy + vb;
    e = '0;
    if (rst) begin
      h = 0; v = 0; fr = '0; lm = '0; ls = '0;
    end else if (en) begin
      em = (h == 0 && v == 0) ? mode  : lm;
      es = (h == 0 && v == 0) ? solid : ls;
      e.dv = (h < va * 0 + ha) && (v < va);
      e.hs = (h >= ha + hf) && (h < ha + hf + hsy);
      e.vs = (v >= va + vf) && (v < va + vf + vsy);
      if (e.dv) begin
        case (em)
          2'd0: e.y = es;
          2'd1: e.y = 8'(h);
          2'd2: e.y = 8'(v);
          default: e.y = (((h >> chk) ^ (v >> chk)) & 1) != 0 ? 8'hFF : 8'h00;
        endcase
      end
      if (h == 0 && v == 0) begin lm = em; ls = es; end
      if (h == ht - 1) begin
        h = 0;
        if (v == vt - 1) begin v = 0; fr = fr + 16'd1; end
        else v = v + 1;
      end else begin
        h = h + 1;
      end
    end
    e.fr = fr;
  endtask

  task automatic tick();
    exp_t es, ed, ps, pd;
    model_step(16, 2, 3, 2, 10, 1, 2, 1, 2, s_rst, s_en, s_mode, s_solid,
               ms_h, ms_v, ms_fr, ms_mode, ms_solid, es);
    q_s.push_back(es);
    model_step(1600, 24, 80, 96, 900, 1, 3, 96, 3, d_rst, d_en, d_mode, d_solid,
               md_h, md_v, md_fr, md_mode, md_solid, ed);
    q_d.push_back(ed);
    @(posedge clk);
    #1;
    ps = q_s.pop_front();
    pd = q_d.pop_front();
    check_val("s_y",  32'(s_y),  32'(ps.y));
    check_val("s_dv", 32'(s_dv), 32'(ps.dv));
    check_val("s_hs", 32'(s_hs), 32'(ps.hs));
    check_val("s_vs", 32'(s_vs), 32'(ps.vs));
    check_val("s_fr", 32'(s_fr), 32'(ps.fr));
    check_val("d_y",  32'(d_y),  32'(pd.y));
    check_val("d_dv", 32'(d_dv), 32'(pd.dv));
    check_val("d_hs", 32'(d_hs), 32'(pd.hs));
    check_val("d_vs", 32'(d_vs), 32'(pd.vs));
    check_val("d_fr", 32'(d_fr), 32'(pd.fr));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int n_dv;
  int n_hs;

  initial begin
    #1;
    run(3);

    // Solid frame, mode change to V-ramp at mid-frame takes effect next frame
    s_rst = 1'b0; s_en = 1'b1; s_mode = 2'd0; s_solid = 8'h5A;
    run(23 * 5 + 7);
    s_mode = 2'd2; s_solid = 8'h33;
    run(322 * 2);
    s_mode = 2'd1; run(322);
    s_mode = 2'd3; run(322);
    check_val("s_frame_cnt", 32'(s_fr), 32'd4);

    // Enable held low for 5 clocks mid-line, then random enable
    run(30);
    s_en = 1'b0; run(5);
    s_en = 1'b1; run(40);
    for (int i = 0; i < 400; i++) begin
      s_en = ($urandom_range(0, 3) != 0);
      tick();
    end
    s_en = 1'b1;
    run(9);

    // Reset mid-line restarts at (0,0)
    s_rst = 1'b1; tick();
    s_rst = 1'b0;
    s_mode = 2'd1;
    tick();
    check_val("s_rst_restart_dv", 32'(s_dv), 32'd1);
    check_val("s_rst_restart_y", 32'(s_y), 32'd0);
    run(330);

    for (int i = 0; i < 14; i++) begin
      s_mode = 2'($urandom_range(0, 3));
      s_solid = 8'($urandom_range(0, 255));
      run(50);
    end
    s_en = 1'b0;

    // Default geometry: H-ramp over two lines, dv/hs counts on line 0
    d_rst = 1'b0; d_en = 1'b1; d_mode = 2'd1;
    n_dv = 0; n_hs = 0;
    for (int i = 0; i < 1800; i++) begin
      tick();
      if (d_dv) n_dv++;
      if (d_hs) n_hs++;
      if (i == 1599) check_val("d_px1599", 32'(d_y), 32'h3F);
      if (i == 256)  check_val("d_px256", 32'(d_y), 32'h00);
      if (i == 1624) check_val("d_hs_rise", 32'(d_hs), 32'd1);
      if (i == 1623) check_val("d_hs_pre", 32'(d_hs), 32'd0);
    end
    check_val("d_dv_per_line", 32'(n_dv), 32'd1600);
    check_val("d_hs_width", 32'(n_hs), 32'd80);
    run(1800);

    // Default geometry: checkerboard over nine lines
    d_rst = 1'b1; tick();
    d_rst = 1'b0; d_mode = 2'd3;
    for (int i = 0; i < 1800 * 9; i++) begin
      tick();
      if (i == 0)           check_val("d_chk_0_0", 32'(d_y), 32'h00);
      if (i == 8)           check_val("d_chk_8_0", 32'(d_y), 32'hFF);
      if (i == 1800 * 8 + 8) check_val("d_chk_8_8", 32'(d_y), 32'h00);
      if (i == 1800 * 8)    check_val("d_chk_0_8", 32'(d_y), 32'hFF);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
